// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback always wins; functional-unit
// results queue in a small FIFO and drain in idle cycles, with starvation stall and WAW query.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_W      = 7,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p_wrd,
    input  logic [REG_W-1:0]      p_regDst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  m_valid,
    output logic                  m_ready,
    input  logic [REG_W-1:0]      m_regDst,
    input  logic [DATA_WIDTH-1:0] m_data,
    output logic                  rf_wrd,
    output logic [REG_W-1:0]      rf_regDst,
    output logic [DATA_WIDTH-1:0] rf_data,
    output logic                  stall_req,
    input  logic [REG_W-1:0]      q_reg,
    output logic                  q_hit
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

    logic [REG_W-1:0]      reg_mem_r  [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
    logic [DEPTH-1:0]      valid_r;
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [AW:0]           count_r;
    logic [SW-1:0]         starve_r;
    logic                  stall_r;

    logic                  push_s;
    logic                  pop_s;
    logic [SW-1:0]         starve_nxt_s;
    logic                  hit_s;

    // A full FIFO stays not-ready even if it drains this cycle.
    assign m_ready   = (count_r < DEPTH_C);
    assign stall_req = stall_r;
    assign q_hit     = hit_s;

    // Handshake decode and next starvation count.
    always_comb begin
        push_s       = m_valid && m_ready;
        pop_s        = !p_wrd && (count_r != '0);
        starve_nxt_s = starve_r;
        if (pop_s) begin
            starve_nxt_s = '0;
        end else if (p_wrd && (count_r != '0)) begin
            starve_nxt_s = (starve_r == STARVE_C) ? starve_r : starve_r + SW'(1);
        end else if ((count_r == '0) && !push_s) begin
            starve_nxt_s = '0;
        end else begin
            starve_nxt_s = starve_r;
        end
    end

    // Destination match against buffered results only.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_r[i] && (reg_mem_r[i] == q_reg)) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // FIFO storage and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_mem_r[i]  <= '0;
                data_mem_r[i] <= '0;
            end
            valid_r  <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + AW'(1);
            end
            if (push_s) begin
                reg_mem_r[wr_ptr_r]  <= m_regDst;
                data_mem_r[wr_ptr_r] <= m_data;
                valid_r[wr_ptr_r]    <= 1'b1;
                wr_ptr_r             <= wr_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Write-port arbitration and starvation tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wrd    <= 1'b0;
            rf_regDst <= '0;
            rf_data   <= '0;
            starve_r  <= '0;
            stall_r   <= 1'b0;
        end else begin
            if (p_wrd) begin
                rf_wrd    <= 1'b1;
                rf_regDst <= p_regDst;
                rf_data   <= p_data;
            end else if (pop_s) begin
                rf_wrd    <= 1'b1;
                rf_regDst <= reg_mem_r[rd_ptr_r];
                rf_data   <= data_mem_r[rd_ptr_r];
            end else begin
                rf_wrd    <= 1'b0;
            end
            starve_r <= starve_nxt_s;
            stall_r  <= (starve_nxt_s == STARVE_C);
        end
    end
endmodule
